// File: rtl/rv_mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM encoding and
// outstanding-read limits.
package rv_mem_pkg;

  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 4;
  localparam int unsigned TXN_CNT_W               = 4;

  typedef enum logic [2:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    DRAIN_I,
    DRAIN_D
  } arb_state_e;

endpackage

// File: rtl/arb_txn_counter.sv
// Counts reads accepted by memory but not yet returned; exposes the
// post-update value so the arbiter can decide its next state this cycle.
module arb_txn_counter
  import rv_mem_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 inc_i,
  input  logic                 dec_i,
  output logic [TXN_CNT_W-1:0] count_next_o,
  output logic                 full_o,
  output logic                 empty_o
);

  logic [TXN_CNT_W-1:0] count_q, count_d;

  assign full_o       = (count_q == TXN_CNT_W'(MAX_OUTSTANDING));
  assign empty_o      = (count_q == '0);
  assign count_next_o = count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && !full_o) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && !empty_o) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction side
// and a data side, with in-order read returns and a sticky protocol-error flag.
module mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter logic        RESET_LAST      = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_imem_addr,
  input  logic        i_imem_ren,
  output logic [31:0] o_imem_rdata,
  output logic        o_imem_ready,
  output logic        o_imem_valid,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_ready,
  output logic        o_dmem_valid,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  output logic        o_err
);

  arb_state_e           state_q, state_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;
  logic                 imem_req, dmem_req, dmem_conflict;
  logic                 rd_accept, rsp_ok;
  logic                 cnt_full, cnt_empty;
  logic [TXN_CNT_W-1:0] cnt_next;

  assign imem_req      = i_imem_ren;
  assign dmem_req      = i_dmem_ren | i_dmem_wen;
  assign dmem_conflict = i_dmem_ren & i_dmem_wen;

  // A response is only legitimate while someone owns the port and owes a read.
  assign rsp_ok    = i_mem_valid && !cnt_empty && (state_q != IDLE);
  assign rd_accept = o_mem_ren && i_mem_ready;

  assign o_imem_rdata = i_mem_rdata;
  assign o_dmem_rdata = i_mem_rdata;
  assign o_imem_valid = rsp_ok && ((state_q == GRANT_I) || (state_q == DRAIN_I));
  assign o_dmem_valid = rsp_ok && ((state_q == GRANT_D) || (state_q == DRAIN_D));
  assign o_err        = err_q;

  arb_txn_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_txn_counter (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .inc_i       (rd_accept),
    .dec_i       (rsp_ok),
    .count_next_o(cnt_next),
    .full_o      (cnt_full),
    .empty_o     (cnt_empty)
  );

  always_comb begin
    o_mem_addr   = '0;
    o_mem_ren    = 1'b0;
    o_mem_wen    = 1'b0;
    o_mem_wdata  = '0;
    o_imem_ready = 1'b0;
    o_dmem_ready = 1'b0;
    case (state_q)
      GRANT_I: begin
        o_mem_addr   = i_imem_addr;
        o_mem_ren    = i_imem_ren && !cnt_full;
        o_imem_ready = i_mem_ready && !cnt_full;
      end
      GRANT_D: begin
        // Write wins over a simultaneous read; a write is never throttled.
        o_mem_addr   = i_dmem_addr;
        o_mem_wdata  = i_dmem_wdata;
        o_mem_wen    = i_dmem_wen;
        o_mem_ren    = i_dmem_ren && !i_dmem_wen && !cnt_full;
        o_dmem_ready = i_mem_ready && (i_dmem_wen || !cnt_full);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    err_d   = err_q | dmem_conflict | (i_mem_valid && !rsp_ok);
    case (state_q)
      IDLE: begin
        if (imem_req && (!dmem_req || last_q)) begin
          state_d = GRANT_I;
          last_d  = 1'b0;
        end else if (dmem_req) begin
          state_d = GRANT_D;
          last_d  = 1'b1;
        end
      end
      GRANT_I: if (!imem_req) state_d = (cnt_next == '0) ? IDLE : DRAIN_I;
      GRANT_D: if (!dmem_req) state_d = (cnt_next == '0) ? IDLE : DRAIN_D;
      DRAIN_I, DRAIN_D: if (cnt_next == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      last_q  <= RESET_LAST;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios for mem_arbiter with a queue-based read-return scoreboard.
module tb_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_imem_addr, i_dmem_addr, i_dmem_wdata, i_mem_rdata;
  logic        i_imem_ren, i_dmem_ren, i_dmem_wen, i_mem_ready, i_mem_valid;
  logic [31:0] o_imem_rdata, o_dmem_rdata, o_mem_addr, o_mem_wdata;
  logic        o_imem_ready, o_imem_valid, o_dmem_ready, o_dmem_valid;
  logic        o_mem_ren, o_mem_wen, o_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  logic [31:0] pend[$];
  logic [31:0] t3_exp[4] = '{32'h0000_0113, 32'h0000_0117, 32'h0000_011B, 32'h0000_011F};
  logic [31:0] t4_exp[3] = '{32'h0000_0213, 32'h0000_0217, 32'h0000_021B};

  always #5 i_clk = ~i_clk;

  mem_arbiter #(
    .MAX_OUTSTANDING(4),
    .RESET_LAST     (1'b0)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_imem_addr (i_imem_addr),
    .i_imem_ren  (i_imem_ren),
    .o_imem_rdata(o_imem_rdata),
    .o_imem_ready(o_imem_ready),
    .o_imem_valid(o_imem_valid),
    .i_dmem_addr (i_dmem_addr),
    .i_dmem_ren  (i_dmem_ren),
    .i_dmem_wen  (i_dmem_wen),
    .i_dmem_wdata(i_dmem_wdata),
    .o_dmem_rdata(o_dmem_rdata),
    .o_dmem_ready(o_dmem_ready),
    .o_dmem_valid(o_dmem_valid),
    .o_mem_addr  (o_mem_addr),
    .o_mem_ren   (o_mem_ren),
    .o_mem_wen   (o_mem_wen),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_ready (i_mem_ready),
    .i_mem_valid (i_mem_valid),
    .o_err       (o_err)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_imem_addr  = '0;
    i_imem_ren   = 1'b0;
    i_dmem_addr  = '0;
    i_dmem_ren   = 1'b0;
    i_dmem_wen   = 1'b0;
    i_dmem_wdata = '0;
    i_mem_rdata  = '0;
    i_mem_valid  = 1'b0;
    i_mem_ready  = 1'b1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  // Memory responder: returns data derived from the address it actually saw.
  task automatic valid_on();
    i_mem_valid = 1'b1;
    if (pend.size() > 0) i_mem_rdata = pend.pop_front();
    else i_mem_rdata = 32'hBAD0_BAD0;
  endtask

  always @(posedge i_clk) begin
    if (o_mem_ren && i_mem_ready) pend.push_back(o_mem_addr ^ 32'h0000_0013);
  end

  // Scoreboard monitor
  always @(negedge i_clk) begin
    if (o_imem_valid) begin
      if (exp_i.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL imem_unexpected_valid: got rdata 0x%08h expected no response", o_imem_rdata);
      end else begin
        check32("imem_rdata", o_imem_rdata, exp_i.pop_front());
      end
    end
    if (o_dmem_valid) begin
      if (exp_d.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dmem_unexpected_valid: got rdata 0x%08h expected no response", o_dmem_rdata);
      end else begin
        check32("dmem_rdata", o_dmem_rdata, exp_d.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    i_imem_ren  = 1'b1;
    i_mem_valid = 1'b1;
    tick();
    @(negedge i_clk);
    check1("rst_imem_ready", o_imem_ready, 1'b0);
    check1("rst_dmem_ready", o_dmem_ready, 1'b0);
    check1("rst_mem_ren",    o_mem_ren,    1'b0);
    check1("rst_mem_wen",    o_mem_wen,    1'b0);
    check1("rst_imem_valid", o_imem_valid, 1'b0);
    check1("rst_dmem_valid", o_dmem_valid, 1'b0);
    check1("rst_err",        o_err,        1'b0);

    // Single I-side read
    do_reset();
    i_imem_addr = 32'h0; i_imem_ren = 1'b1;
    @(negedge i_clk);
    check1("t1_idle_ready", o_imem_ready, 1'b0);
    tick();
    @(negedge i_clk);
    check1("t1_grant_ready", o_imem_ready, 1'b1);
    check1("t1_mem_ren", o_mem_ren, 1'b1);
    check32("t1_mem_addr", o_mem_addr, 32'h0);
    exp_i.push_back(32'h0000_0013);
    tick();
    i_imem_ren = 1'b0;
    tick();
    valid_on();
    tick();
    i_mem_valid = 1'b0;
    tick();

    // Simultaneous requests: D first, then I after an IDLE cycle
    do_reset();
    i_imem_addr = 32'h40; i_imem_ren = 1'b1;
    i_dmem_addr = 32'h80; i_dmem_ren = 1'b1;
    @(negedge i_clk);
    check1("t2_idle_dready", o_dmem_ready, 1'b0);
    tick();
    @(negedge i_clk);
    check1("t2_d_granted", o_dmem_ready, 1'b1);
    check1("t2_i_blocked", o_imem_ready, 1'b0);
    check32("t2_d_addr", o_mem_addr, 32'h80);
    exp_d.push_back(32'h0000_0093);
    tick();
    i_dmem_ren = 1'b0;
    @(negedge i_clk);
    check1("t2_i_blocked_grant", o_imem_ready, 1'b0);
    tick();
    valid_on();
    @(negedge i_clk);
    check1("t2_i_blocked_drain", o_imem_ready, 1'b0);
    tick();
    i_mem_valid = 1'b0;
    @(negedge i_clk);
    check1("t2_idle_gap", o_imem_ready, 1'b0);
    tick();
    @(negedge i_clk);
    check1("t2_i_granted", o_imem_ready, 1'b1);
    check32("t2_i_addr", o_mem_addr, 32'h40);
    exp_i.push_back(32'h0000_0053);
    tick();
    i_imem_ren = 1'b0;
    valid_on();
    tick();
    i_mem_valid = 1'b0;
    tick();

    // Outstanding limit on an I burst
    do_reset();
    i_imem_ren = 1'b1; i_imem_addr = 32'h100;
    tick();
    for (int k = 0; k < 4; k++) begin
      i_imem_addr = 32'h100 + 32'(4 * k);
      @(negedge i_clk);
      check1("t3_burst_ready", o_imem_ready, 1'b1);
      exp_i.push_back(t3_exp[k]);
      tick();
    end
    i_imem_addr = 32'h110;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check1("t3_full_ready", o_imem_ready, 1'b0);
      check1("t3_full_ren", o_mem_ren, 1'b0);
      tick();
    end
    valid_on();
    @(negedge i_clk);
    check1("t3_full_valid_cycle", o_imem_ready, 1'b0);
    tick();
    i_mem_valid = 1'b0;
    @(negedge i_clk);
    check1("t3_resume_ready", o_imem_ready, 1'b1);
    check1("t3_resume_ren", o_mem_ren, 1'b1);
    exp_i.push_back(32'h0000_0103);
    tick();
    i_imem_ren = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid_on();
      tick();
    end
    i_mem_valid = 1'b0;
    tick();

    // Drain I reads before a pending D write is granted
    do_reset();
    i_imem_ren = 1'b1; i_imem_addr = 32'h200;
    tick();
    for (int k = 0; k < 3; k++) begin
      i_imem_addr = 32'h200 + 32'(4 * k);
      @(negedge i_clk);
      check1("t4_burst_ready", o_imem_ready, 1'b1);
      exp_i.push_back(t4_exp[k]);
      tick();
    end
    i_imem_ren = 1'b0;
    i_dmem_wen = 1'b1; i_dmem_addr = 32'h2000; i_dmem_wdata = 32'hCAFE_F00D;
    @(negedge i_clk);
    check1("t4_d_ignored", o_dmem_ready, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      valid_on();
      @(negedge i_clk);
      check1("t4_drain_dready", o_dmem_ready, 1'b0);
      check1("t4_drain_wen", o_mem_wen, 1'b0);
      tick();
    end
    i_mem_valid = 1'b0;
    @(negedge i_clk);
    check1("t4_idle_wen", o_mem_wen, 1'b0);
    check1("t4_idle_dready", o_dmem_ready, 1'b0);
    tick();
    @(negedge i_clk);
    check1("t4_write_wen", o_mem_wen, 1'b1);
    check1("t4_write_ren", o_mem_ren, 1'b0);
    check1("t4_write_ready", o_dmem_ready, 1'b1);
    check32("t4_write_addr", o_mem_addr, 32'h2000);
    check32("t4_write_data", o_mem_wdata, 32'hCAFE_F00D);
    tick();
    i_dmem_wen = 1'b0;
    tick();

    // Protocol errors: D ren+wen, then spurious response in IDLE
    do_reset();
    i_dmem_addr = 32'h3000; i_dmem_ren = 1'b1; i_dmem_wen = 1'b1; i_dmem_wdata = 32'h1234_5678;
    @(negedge i_clk);
    check1("t5_err_pre", o_err, 1'b0);
    tick();
    @(negedge i_clk);
    check1("t5_conflict_err", o_err, 1'b1);
    check1("t5_conflict_wen", o_mem_wen, 1'b1);
    check1("t5_conflict_ren", o_mem_ren, 1'b0);
    tick();
    i_dmem_ren = 1'b0; i_dmem_wen = 1'b0;
    repeat (3) tick();
    @(negedge i_clk);
    check1("t5_err_sticky", o_err, 1'b1);
    do_reset();
    @(negedge i_clk);
    check1("t5_err_cleared", o_err, 1'b0);
    valid_on();
    tick();
    i_mem_valid = 1'b0;
    @(negedge i_clk);
    check1("t5_spurious_err", o_err, 1'b1);
    tick();
    tick();
    @(negedge i_clk);
    check1("t5_spurious_sticky", o_err, 1'b1);

    // Reset mid-burst, late response after release
    do_reset();
    i_imem_ren = 1'b1; i_imem_addr = 32'h400;
    tick();
    @(negedge i_clk);
    check1("t6_first_ready", o_imem_ready, 1'b1);
    tick();
    i_imem_addr = 32'h404;
    @(negedge i_clk);
    check1("t6_second_ready", o_imem_ready, 1'b1);
    tick();
    check1("t6_pre_reset_ready", o_imem_ready, 1'b1);
    i_rst_n = 1'b0;
    #1;
    check1("t6_async_ready", o_imem_ready, 1'b0);
    check1("t6_async_ren", o_mem_ren, 1'b0);
    i_imem_ren = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    valid_on();
    @(negedge i_clk);
    check1("t6_late_no_valid", o_imem_valid, 1'b0);
    tick();
    i_mem_valid = 1'b0;
    @(negedge i_clk);
    check1("t6_late_err", o_err, 1'b1);
    pend.delete();
    tick();

    check32("exp_i_drained", 32'(exp_i.size()), 32'd0);
    check32("exp_d_drained", 32'(exp_d.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
